// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags and an iterative shift-add multiplier.
// Define ALU_SEQ_DIV_EN to add the N-cycle restoring divider (opcodes div/rem).
module alu_seq #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic [N-1:0] y_hi,
  output logic         flg_z,
  output logic         flg_c,
  output logic         flg_v,
  output logic         flg_n,
  output logic         flg_err
);
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_MUL  = 4'h8;
  localparam logic [3:0] OP_SLT  = 4'h9;
  localparam logic [3:0] OP_SLTU = 4'hA;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] OP_DIV  = 4'hB;
  localparam logic [3:0] OP_REM  = 4'hC;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        r_state;
  logic [SW-1:0] r_cnt;
  logic [N-1:0]  r_a, r_hi, r_lo;
  logic [N-1:0]  r_y, r_y_hi;
  logic          r_z, r_c, r_v, r_n, r_err;
`ifdef ALU_SEQ_DIV_EN
  logic [N-1:0]  r_b;
  logic [3:0]    r_op;
  logic [N:0]    w_trial;
`endif

  logic          w_multi;
  logic [N:0]    w_sum, w_diff, w_madd;
  logic [N-1:0]  w_y;
  logic          w_c, w_v, w_err;
  logic [SW-1:0] w_sh;
  logic [N-1:0]  w_hi_next, w_lo_next, w_fy, w_fyh;
  logic          w_fz, w_fc, w_ferr;

  assign w_sh   = b[SW-1:0];
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};

  always_comb begin
    w_multi = (op == OP_MUL);
`ifdef ALU_SEQ_DIV_EN
    if (op == OP_DIV || op == OP_REM) w_multi = 1'b1;
`endif
  end

  always_comb begin
    w_y   = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    case (op)
      OP_ADD: begin
        w_y = w_sum[N-1:0];
        w_c = w_sum[N];
        w_v = (a[N-1] == b[N-1]) && (w_sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        // Carry out of a + ~b + 1 is "no borrow", so the flag is its inverse.
        w_y = w_diff[N-1:0];
        w_c = ~w_diff[N];
        w_v = (a[N-1] != b[N-1]) && (w_diff[N-1] != a[N-1]);
      end
      OP_AND:  w_y = a & b;
      OP_OR:   w_y = a | b;
      OP_XOR:  w_y = a ^ b;
      OP_SLL:  w_y = a << w_sh;
      OP_SRL:  w_y = a >> w_sh;
      OP_SRA:  w_y = $unsigned($signed(a) >>> w_sh);
      OP_SLT:  w_y = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_y = {{(N-1){1'b0}}, (a < b)};
      default: w_err = 1'b1;
    endcase
  end

  // One iteration: shift-add for mul, restoring subtract for div (hi=partial, lo=operand/quotient).
  always_comb begin
    w_madd    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(N+1){1'b0}});
    w_hi_next = w_madd[N:1];
    w_lo_next = {w_madd[0], r_lo[N-1:1]};
`ifdef ALU_SEQ_DIV_EN
    w_trial = {r_hi, r_lo[N-1]} - {1'b0, r_b};
    if (r_op != OP_MUL) begin
      if (!w_trial[N]) begin
        w_hi_next = w_trial[N-1:0];
        w_lo_next = {r_lo[N-2:0], 1'b1};
      end else begin
        w_hi_next = {r_hi[N-2:0], r_lo[N-1]};
        w_lo_next = {r_lo[N-2:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    w_fy   = w_lo_next;
    w_fyh  = w_hi_next;
    w_fc   = |w_hi_next;
    w_ferr = 1'b0;
    w_fz   = (w_lo_next == '0) && (w_hi_next == '0);
`ifdef ALU_SEQ_DIV_EN
    if (r_op != OP_MUL) begin
      w_fc   = 1'b0;
      w_ferr = (r_b == '0);
      if (r_op == OP_REM) begin
        w_fy  = w_hi_next;
        w_fyh = w_lo_next;
      end
      w_fz = (w_fy == '0);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_y     <= '0;
      r_y_hi  <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
      r_n     <= 1'b0;
      r_err   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      r_b     <= '0;
      r_op    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          if (w_multi) begin
            r_state <= BUSY;
            r_cnt   <= SW'(N - 1);
            r_a     <= a;
            r_hi    <= '0;
`ifdef ALU_SEQ_DIV_EN
            r_lo    <= (op == OP_MUL) ? b : a;
            r_b     <= b;
            r_op    <= op;
`else
            r_lo    <= b;
`endif
          end else begin
            r_state <= DONE;
            r_y     <= w_y;
            r_y_hi  <= '0;
            r_z     <= (w_y == '0);
            r_c     <= w_c;
            r_v     <= w_v;
            r_n     <= w_y[N-1];
            r_err   <= w_err;
          end
        end
        BUSY: begin
          r_hi  <= w_hi_next;
          r_lo  <= w_lo_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= DONE;
            r_y     <= w_fy;
            r_y_hi  <= w_fyh;
            r_z     <= w_fz;
            r_c     <= w_fc;
            r_v     <= w_fc;
            r_n     <= w_fy[N-1];
            r_err   <= w_ferr;
          end
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign y         = r_y;
  assign y_hi      = r_y_hi;
  assign flg_z     = r_z;
  assign flg_c     = r_c;
  assign flg_v     = r_v;
  assign flg_n     = r_n;
  assign flg_err   = r_err;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed + random scoreboard bench for alu_seq (N=8); honours ALU_SEQ_DIV_EN.
module tb_alu_seq;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   op;
  logic [N-1:0] a, b, y, y_hi;
  logic         flg_z, flg_c, flg_v, flg_n, flg_err;
  logic [4:0]   tb_flags;

  always #5 clk = ~clk;

  alu_seq #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .y_hi(y_hi), .flg_z(flg_z),
    .flg_c(flg_c), .flg_v(flg_v), .flg_n(flg_n), .flg_err(flg_err)
  );

  assign tb_flags = {flg_z, flg_c, flg_v, flg_n, flg_err};

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] yh;
    logic [4:0] f;   // {z,c,v,n,err}
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] yv, input logic [7:0] yhv,
                              input logic z, input logic c, input logic v,
                              input logic n, input logic err);
    exp_t e;
    e.y  = yv;
    e.yh = yhv;
    e.f  = {z, c, v, n, err};
    return e;
  endfunction

  function automatic exp_t model(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv);
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  r, h;
    logic        c, v, err, z;
    r = '0; h = '0; c = 1'b0; v = 1'b0; err = 1'b0;
    case (o)
      4'h0: begin
        s = {1'b0, av} + {1'b0, bv};
        r = s[7:0];
        c = s[8];
        v = (av[7] == bv[7]) && (r[7] != av[7]);
      end
      4'h1: begin
        r = av - bv;
        c = (av < bv);
        v = (av[7] != bv[7]) && (r[7] != av[7]);
      end
      4'h2: r = av & bv;
      4'h3: r = av | bv;
      4'h4: r = av ^ bv;
      4'h5: r = av << bv[2:0];
      4'h6: r = av >> bv[2:0];
      4'h7: r = 8'($signed(av) >>> bv[2:0]);
      4'h8: begin
        p = 16'(av) * 16'(bv);
        r = p[7:0];
        h = p[15:8];
        c = (h != 8'h00);
        v = c;
      end
      4'h9: r = {7'b0, ($signed(av) < $signed(bv))};
      4'hA: r = {7'b0, (av < bv)};
`ifdef ALU_SEQ_DIV_EN
      4'hB, 4'hC: begin
        logic [7:0] q, m;
        if (bv == 8'h00) begin
          q = 8'hFF; m = av; err = 1'b1;
        end else begin
          q = av / bv; m = av % bv;
        end
        r = (o == 4'hB) ? q : m;
        h = (o == 4'hB) ? m : q;
      end
`endif
      default: err = 1'b1;
    endcase
    z = (o == 4'h8) ? ({h, r} == 16'h0000) : (r == 8'h00);
    return mk(r, h, z, c, v, r[7], err);
  endfunction

  function automatic int lat_of(input logic [3:0] o);
`ifdef ALU_SEQ_DIV_EN
    if (o == 4'hB || o == 4'hC) return N + 1;
`endif
    return (o == 4'h8) ? N + 1 : 1;
  endfunction

  task automatic send(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv);
    int w;
    w = 0;
    op = o; a = av; b = bv; in_valid = 1'b1;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    // Scramble inputs after acceptance: the DUT must work from its captured copy.
    in_valid = 1'b0;
    op = 4'($urandom);
    a  = 8'($urandom);
    b  = 8'($urandom);
  endtask

  task automatic collect(input int exp_lat, input int hold);
    exp_t  e;
    string tag;
    int    cyc, low;
    e = sb_q.pop_front();
    tag = tag_q.pop_front();
    cyc = 1;
    low = 0;
    while (!out_valid && cyc < 40) begin
      if (!in_ready) low++;
      @(posedge clk); #1; cyc++;
    end
    if (!in_ready) low++;
    chk8({tag, " out_valid"}, {7'b0, out_valid}, 8'h01);
    chk8({tag, " y"}, y, e.y);
    chk8({tag, " y_hi"}, y_hi, e.yh);
    chk8({tag, " flags"}, {3'b0, tb_flags}, {3'b0, e.f});
    chk_int({tag, " latency"}, cyc, exp_lat);
    chk_int({tag, " in_ready low cycles"}, low, exp_lat);
    $display("txn %s: y=%02h y_hi=%02h zcvne=%05b latency=%0d", tag, y, y_hi, tb_flags, cyc);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk8({tag, " held y"}, y, e.y);
      chk8({tag, " held flags"}, {3'b0, tb_flags}, {3'b0, e.f});
      chk8({tag, " held ready/valid"}, {6'b0, in_ready, out_valid}, 8'h01);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk8({tag, " after handshake ready/valid"}, {6'b0, in_ready, out_valid}, 8'h02);
  endtask

  task automatic run(input string tag, input logic [3:0] o, input logic [7:0] av,
                     input logic [7:0] bv, input exp_t e);
    sb_q.push_back(e);
    tag_q.push_back(tag);
    send(o, av, bv);
    collect(lat_of(o), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_valid;
    logic [3:0] ro;
    logic [7:0] ra, rb;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    #2;
    chk8("reset y", y, 8'h00);
    chk8("reset y_hi", y_hi, 8'h00);
    chk8("reset flags", {3'b0, tb_flags}, 8'h00);
    chk8("reset ready/valid", {6'b0, in_ready, out_valid}, 8'h02);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    run("add_ovf",  4'h0, 8'h7F, 8'h01, mk(8'h80, 8'h00, 0, 0, 1, 1, 0));
    run("add_wrap", 4'h0, 8'hFF, 8'h01, mk(8'h00, 8'h00, 1, 1, 0, 0, 0));
    run("sub_brw",  4'h1, 8'h05, 8'h07, mk(8'hFE, 8'h00, 0, 1, 0, 1, 0));
    run("sub_ovf",  4'h1, 8'h80, 8'h01, mk(8'h7F, 8'h00, 0, 0, 1, 0, 0));
    run("and",      4'h2, 8'hF0, 8'h3C, mk(8'h30, 8'h00, 0, 0, 0, 0, 0));
    run("or",       4'h3, 8'hF0, 8'h3C, mk(8'hFC, 8'h00, 0, 0, 0, 1, 0));
    run("xor",      4'h4, 8'hF0, 8'h3C, mk(8'hCC, 8'h00, 0, 0, 0, 1, 0));
    run("mul_max",  4'h8, 8'hFF, 8'hFF, mk(8'h01, 8'hFE, 0, 1, 1, 0, 0));
    run("mul_zero", 4'h8, 8'h00, 8'h37, mk(8'h00, 8'h00, 1, 0, 0, 0, 0));
    run("mul_hi",   4'h8, 8'h10, 8'h10, mk(8'h00, 8'h01, 0, 1, 1, 0, 0));
    run("sra",      4'h7, 8'h80, 8'h03, mk(8'hF0, 8'h00, 0, 0, 0, 1, 0));
    run("sll_mod",  4'h5, 8'h01, 8'h09, mk(8'h02, 8'h00, 0, 0, 0, 0, 0));
    run("srl",      4'h6, 8'h80, 8'h07, mk(8'h01, 8'h00, 0, 0, 0, 0, 0));
    run("slt",      4'h9, 8'hFF, 8'h01, mk(8'h01, 8'h00, 0, 0, 0, 0, 0));
    run("sltu",     4'hA, 8'hFF, 8'h01, mk(8'h00, 8'h00, 1, 0, 0, 0, 0));
    run("illegal",  4'hF, 8'h12, 8'h34, mk(8'h00, 8'h00, 1, 0, 0, 0, 1));
`ifdef ALU_SEQ_DIV_EN
    run("div",      4'hB, 8'h64, 8'h07, mk(8'h0E, 8'h02, 0, 0, 0, 0, 0));
    run("rem",      4'hC, 8'h64, 8'h07, mk(8'h02, 8'h0E, 0, 0, 0, 0, 0));
    run("div_zero", 4'hB, 8'h5A, 8'h00, mk(8'hFF, 8'h5A, 0, 0, 0, 1, 1));
`else
    run("op_b_ill", 4'hB, 8'h64, 8'h07, mk(8'h00, 8'h00, 1, 0, 0, 0, 1));
    run("op_c_ill", 4'hC, 8'h64, 8'h07, mk(8'h00, 8'h00, 1, 0, 0, 0, 1));
`endif

    // Backpressure: sink stalls for 5 cycles in DONE.
    sb_q.push_back(mk(8'h80, 8'h00, 0, 0, 1, 1, 0));
    tag_q.push_back("add_bp");
    out_ready = 1'b0;
    send(4'h0, 8'h7F, 8'h01);
    collect(1, 5);

    // Reset asserted in the 4th BUSY cycle of a multiply: result must vanish.
    send(4'h8, 8'hAB, 8'hCD);
    repeat (3) begin @(posedge clk); #1; end
    chk8("midrst pre ready/valid", {6'b0, in_ready, out_valid}, 8'h00);
    rst_n = 1'b0;
    #1;
    chk8("midrst y", y, 8'h00);
    chk8("midrst y_hi", y_hi, 8'h00);
    chk8("midrst flags", {3'b0, tb_flags}, 8'h00);
    chk8("midrst ready/valid", {6'b0, in_ready, out_valid}, 8'h02);
    #2 rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    chk8("midrst no out_valid", {7'b0, seen_valid}, 8'h00);
    chk8("midrst idle ready", {7'b0, in_ready}, 8'h01);
    $display("txn midrst: mul discarded by reset, in_ready=%0b", in_ready);

    for (int i = 0; i < 24; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = 8'($urandom);
      run($sformatf("rnd%0d_op%0h_%02h_%02h", i, ro, ra, rb), ro, ra, rb, model(ro, ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Second-generation parametrised ALU with registered outputs, a valid/ready handshake on both sides, and a full flag set (Z/C/V/N/ERR).
- Adds iterative multi-cycle operations: a shift-add multiplier and an optional restoring divider.
- Single-cycle ops complete in one cycle; multi-cycle ops stall the input side until they finish.
- Sits between the operand/opcode source and the result sink in the datapath.

Parameters:
- N, 8, operand/result width; legal values are N >= 4, power of two.
- SW, $clog2(N), shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and opcode are valid.
- in_ready  out  1  block can accept a new operation.
- op  in  4  opcode.
- a  in  N  operand A.
- b  in  N  operand B; for shifts, only b[SW-1:0] is used.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  sink accepts the result.
- y  out  N  result, low half.
- y_hi  out  N  mul: product high half; div/rem: the other result; otherwise 0.
- flg_z  out  1  zero flag.
- flg_c  out  1  carry/borrow flag.
- flg_v  out  1  overflow flag.
- flg_n  out  1  negative flag (y[N-1]).
- flg_err  out  1  illegal opcode or divide-by-zero.

Behaviour:
- Reset (async assert, sync release): state=IDLE; y, y_hi, all flags = 0; out_valid=0; in_ready=1.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state==IDLE). An op is accepted when in_valid && in_ready; a, b and op are captured at acceptance.
- IDLE -> DONE on accept of a single-cycle op. out_valid=1 on the cycle after the accept edge.
- IDLE -> BUSY on accept of mul/div/rem. The step counter loads N-1. BUSY lasts exactly N cycles, then -> DONE. out_valid rises N+1 cycles after the accept edge.
- DONE: out_valid=1. y, y_hi and flags are held stable until out_ready=1, then -> IDLE. in_ready is high on the following cycle.
- Opcodes:
  - 0000 add
  - 0001 sub
  - 0010 and
  - 0011 or
  - 0100 xor
  - 0101 sll
  - 0110 srl
  - 0111 sra
  - 1000 mul (unsigned, N cycles)
  - 1001 slt (signed)
  - 1010 sltu
  - 1011 div (DIV_EN)
  - 1100 rem (DIV_EN)
  - 1101-1111 illegal
- Flags:
  - flg_z = (y==0) for all ops; for mul, flg_z = ({y_hi,y}==0).
  - add: flg_c = carry out of the N-bit sum; flg_v = signed overflow.
  - sub: a + ~b + 1; flg_c = borrow (1 when a < b unsigned); flg_v = signed overflow.
  - Logic, shift and compare ops: flg_c = flg_v = 0.
  - mul: flg_c = flg_v = (y_hi != 0).
  - slt/sltu: y = {N-1 zeros, result bit}.
  - flg_n = y[N-1] for every op.
- Shifts: only b[SW-1:0] is used (amount mod N). sra fills with a[N-1].
- Illegal opcode: completes as single-cycle; y = y_hi = 0; flg_err=1; other flags 0 except flg_z=1.
- Reset mid-operation: the BUSY or DONE result is discarded; the block returns to reset values immediately.
- in_valid while busy: ignored. The source must hold the operation until in_ready.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- Defined:
  - Opcodes 1011/1100 use an N-cycle restoring unsigned divider sharing the BUSY state and step counter.
  - div: y = quotient, y_hi = remainder. rem: y = remainder, y_hi = quotient.
  - Divide by zero: quotient = all ones, remainder = a, flg_err=1, same N+1-cycle latency.
- Undefined: 1011/1100 are treated as illegal opcodes and no divider logic is synthesised.

Test Plan:
- N=8, add a=0x7F, b=0x01 -> y=0x80, flg_v=1, flg_n=1, flg_c=0, flg_z=0, out_valid one cycle after accept.
- sub a=0x05, b=0x07 -> y=0xFE, flg_c=1, flg_n=1.
- sub a=0x80, b=0x01 -> y=0x7F, flg_v=1.
- mul a=0xFF, b=0xFF -> y=0x01, y_hi=0xFE, flg_c=flg_v=1; in_ready low 9 cycles; out_valid exactly 9 cycles after accept.
- sra a=0x80, b=0x03 -> y=0xF0.
- sll a=0x01, b=0x09 -> y=0x02 (amount mod 8).
- slt a=0xFF, b=0x01 -> y=0x01.
- sltu with the same operands -> y=0x00.
- Backpressure: hold out_ready=0 for 5 cycles after an add -> y and flags stable, in_ready=0 throughout, next op accepted only after the out_ready handshake.
- Assert rst_n=0 at BUSY cycle 4 of a mul -> outputs zero immediately, in_ready=1, no out_valid.
- op=1111 -> y=0, flg_err=1, flg_z=1.
- With ALU_SEQ_DIV_EN: div a=0x64, b=0x07 -> y=0x0E, y_hi=0x02; div b=0 -> y=0xFF, y_hi=a, flg_err=1.
